// File: rtl/vga_pkg.sv
// Shared definitions for the VGA fill controller: packed-pixel field layout,
// FSM state encoding and a pixel packing helper.
package vga_pkg;

  localparam int X_LSB = 0;
  localparam int Y_LSB = 10;
  localparam int C_LSB = 20;
  localparam int X_W   = 10;
  localparam int Y_W   = 10;
  localparam int C_W   = 12;
  localparam int PIX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  function automatic logic [PIX_W-1:0] pack_pixel(input logic [C_W-1:0] colour,
                                                  input logic [Y_W-1:0] y,
                                                  input logic [X_W-1:0] x);
    logic [PIX_W-1:0] p;
    p = '0;
    p[X_LSB +: X_W] = x;
    p[Y_LSB +: Y_W] = y;
    p[C_LSB +: C_W] = colour;
    return p;
  endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// Raster-order x/y stepper over an inclusive rectangle; x is the inner loop.
// Holds on the last pixel so the counters never leave the rectangle.
module vga_raster_counter
  import vga_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           enable,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  assign last = (x == x1) && (y == y1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= x0;
      y <= y0;
    end else if (enable && !last) begin
      if (x == x1) begin
        x <= x0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_fill_ctrl.sv
// Rectangle-fill engine for a frame buffer with CPU pixel writes taking
// strict priority over fill writes on a single registered write port.
module vga_fill_ctrl
  import vga_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 800,
  parameter int DISPLAY_HEIGHT = 600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_we,
  input  logic [PIX_W-1:0] cpu_wdata,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [X_W-1:0]   cmd_x0,
  input  logic [Y_W-1:0]   cmd_y0,
  input  logic [X_W-1:0]   cmd_x1,
  input  logic [Y_W-1:0]   cmd_y1,
  input  logic [C_W-1:0]   cmd_colour,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             vga_we,
  output logic [PIX_W-1:0] vga_wdata
);

  localparam logic [X_W-1:0] X_MAX = X_W'(DISPLAY_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(DISPLAY_HEIGHT - 1);

  fill_state_e    state_q, state_d;
  logic [X_W-1:0] x0_q, x1_q, x_cnt;
  logic [Y_W-1:0] y0_q, y1_q, y_cnt;
  logic [C_W-1:0] colour_q;
  logic [X_W-1:0] x1_clamp;
  logic [Y_W-1:0] y1_clamp;
  logic           accept, rect_empty, fill_step, cnt_last;

  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign x1_clamp  = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
  assign y1_clamp  = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
  // An origin off-screen is always greater than the clamped far corner.
  assign rect_empty = (cmd_x0 > x1_clamp) || (cmd_y0 > y1_clamp) ||
                      (cmd_x0 > X_MAX)    || (cmd_y0 > Y_MAX);
  assign fill_step = (state_q == ST_FILL) && !cpu_we;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments; reset is synchronous, active-low.
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (accept) state_d = rect_empty ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        if (abort)                     state_d = ST_IDLE;
        else if (fill_step && cnt_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
    end else if (accept) begin
      x0_q     <= cmd_x0;
      x1_q     <= x1_clamp;
      y0_q     <= cmd_y0;
      y1_q     <= y1_clamp;
      colour_q <= cmd_colour;
    end
  end

  // Load sees the incoming origin; stepping wraps back to the latched one.
  vga_raster_counter u_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && !rect_empty),
    .enable (fill_step),
    .x0     (accept ? cmd_x0 : x0_q),
    .x1     (x1_q),
    .y0     (accept ? cmd_y0 : y0_q),
    .y1     (y1_q),
    .x      (x_cnt),
    .y      (y_cnt),
    .last   (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      vga_we    <= 1'b0;
      vga_wdata <= '0;
    end else if (cpu_we) begin
      vga_we    <= 1'b1;
      vga_wdata <= cpu_wdata;
    end else if (fill_step) begin
      vga_we    <= 1'b1;
      vga_wdata <= pack_pixel(colour_q, y_cnt, x_cnt);
    end else begin
      vga_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Self-checking bench for vga_fill_ctrl: directed scenarios plus random
// traffic, compared cycle by cycle against a pixel-list reference model.
module tb_vga_fill_ctrl;

  localparam int W = 800;
  localparam int H = 600;

  logic        clk = 1'b0;
  logic        rst, cpu_we, cmd_valid, cmd_ready, abort, busy, done, vga_we;
  logic [31:0] cpu_wdata, vga_wdata;
  logic [9:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [11:0] cmd_colour;

  vga_fill_ctrl #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_x1     (cmd_x1),
    .cmd_y1     (cmd_y1),
    .cmd_colour (cmd_colour),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .vga_we     (vga_we),
    .vga_wdata  (vga_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic        cmd_valid;
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  x1;
    logic [9:0]  y1;
    logic [11:0] colour;
    logic        abort;
  } stim_t;

  int n_checks = 0;
  int n_errors = 0;
  int obs_writes = 0;

  // Reference model: pending fill pixels, plus what the outputs should show.
  bit          model_valid = 1'b0;
  bit          m_filling   = 1'b0;
  bit          m_done      = 1'b0;
  logic        m_we        = 1'b0;
  logic [31:0] m_data      = '0;
  logic [31:0] fill_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t cmd_s(input int x0, input int y0, input int x1, input int y1,
                                  input logic [11:0] colour);
    stim_t s;
    s = idle_s();
    s.cmd_valid = 1'b1;
    s.x0 = 10'(x0);
    s.y0 = 10'(y0);
    s.x1 = 10'(x1);
    s.y1 = 10'(y1);
    s.colour = colour;
    return s;
  endfunction

  function automatic void build_rect(input int x0, input int y0, input int x1, input int y1,
                                     input logic [11:0] colour);
    int xe, ye;
    xe = (x1 > W - 1) ? W - 1 : x1;
    ye = (y1 > H - 1) ? H - 1 : y1;
    fill_q.delete();
    if (x0 > xe || y0 > ye || x0 >= W || y0 >= H) return;
    for (int y = y0; y <= ye; y++)
      for (int x = x0; x <= xe; x++)
        fill_q.push_back({colour, 10'(y), 10'(x)});
  endfunction

  // One clock: check what the last edge produced, drive new inputs, predict.
  task automatic apply(input stim_t s);
    bit popped_last, new_done;
    @(negedge clk);
    if (model_valid) begin
      check("vga_we", vga_we, m_we);
      check("vga_wdata", vga_wdata, m_data);
      check("cmd_ready", cmd_ready, !(m_filling || m_done));
      check("busy", busy, m_filling || m_done);
      check("done", done, m_done);
    end
    if (vga_we === 1'b1) obs_writes++;
    rst = s.rst; cpu_we = s.cpu_we; cpu_wdata = s.cpu_wdata; cmd_valid = s.cmd_valid;
    cmd_x0 = s.x0; cmd_y0 = s.y0; cmd_x1 = s.x1; cmd_y1 = s.y1;
    cmd_colour = s.colour; abort = s.abort;

    popped_last = 1'b0;
    new_done    = 1'b0;
    if (!s.rst) begin
      model_valid = 1'b1;
      m_filling = 1'b0; m_done = 1'b0; m_we = 1'b0; m_data = '0;
      fill_q.delete();
    end else begin
      if (s.cpu_we) begin
        m_we = 1'b1; m_data = s.cpu_wdata;
      end else if (m_filling) begin
        m_we = 1'b1; m_data = fill_q.pop_front();
        popped_last = (fill_q.size() == 0);
      end else begin
        m_we = 1'b0;
      end
      if (m_filling) begin
        if (s.abort) begin
          m_filling = 1'b0;
          fill_q.delete();
        end else if (popped_last) begin
          m_filling = 1'b0;
          new_done  = 1'b1;
        end
      end else if (!m_done && s.cmd_valid) begin
        build_rect(int'(s.x0), int'(s.y0), int'(s.x1), int'(s.y1), s.colour);
        if (fill_q.size() == 0) new_done = 1'b1;
        else                    m_filling = 1'b1;
      end
      m_done = new_done;
    end
  endtask

  function automatic logic [9:0] rnd_coord(input int border);
    case ($urandom_range(0, 2))
      0:       return 10'($urandom_range(0, 7));
      1:       return 10'($urandom_range(border - 3, border + 3));
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    stim_t s;
    int    base;

    s = idle_s();
    s.rst = 1'b0;
    apply(s);
    apply(s);

    // Single-row fill of three pixels.
    base = obs_writes;
    apply(cmd_s(2, 3, 4, 3, 12'hF0F));
    repeat (6) apply(idle_s());
    check("row_writes", obs_writes - base, 3);

    // CPU write interleaved on the second fill cycle.
    base = obs_writes;
    apply(cmd_s(0, 0, 1, 1, 12'h123));
    apply(idle_s());
    s = idle_s();
    s.cpu_we = 1'b1;
    s.cpu_wdata = 32'h0010_0005;
    apply(s);
    repeat (6) apply(idle_s());
    check("cpu_mix_writes", obs_writes - base, 5);

    // Far corner clamped to the display edge.
    base = obs_writes;
    apply(cmd_s(798, 599, 1023, 1023, 12'hABC));
    repeat (5) apply(idle_s());
    check("clamp_writes", obs_writes - base, 2);

    // Empty rectangle.
    base = obs_writes;
    apply(cmd_s(5, 0, 4, 0, 12'h777));
    repeat (3) apply(idle_s());
    check("empty_writes", obs_writes - base, 0);

    // Abort on the last-pixel cycle: pixel written, no done.
    base = obs_writes;
    apply(cmd_s(0, 0, 2, 0, 12'h00F));
    apply(idle_s());
    apply(idle_s());
    s = idle_s();
    s.abort = 1'b1;
    apply(s);
    repeat (4) apply(idle_s());
    check("abort_last_writes", obs_writes - base, 3);

    // Full-screen fill aborted after 100 pixels; a command mid-fill is ignored.
    base = obs_writes;
    apply(cmd_s(0, 0, 799, 599, 12'h555));
    for (int i = 1; i < 100; i++) begin
      s = (i == 50) ? cmd_s(7, 7, 9, 9, 12'hEEE) : idle_s();
      apply(s);
    end
    s = idle_s();
    s.abort = 1'b1;
    apply(s);
    repeat (4) apply(idle_s());
    check("abort_writes", obs_writes - base, 100);

    // Reset in the middle of a fill.
    base = obs_writes;
    apply(cmd_s(0, 0, 799, 599, 12'h321));
    repeat (20) apply(idle_s());
    s = idle_s();
    s.rst = 1'b0;
    apply(s);
    repeat (4) apply(idle_s());
    check("reset_writes", obs_writes - base, 20);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      s = idle_s();
      s.rst       = ($urandom_range(0, 199) != 0);
      s.cpu_we    = ($urandom_range(0, 4) == 0);
      s.cpu_wdata = $urandom;
      s.cmd_valid = ($urandom_range(0, 3) == 0);
      s.x0        = rnd_coord(W);
      s.y0        = rnd_coord(H);
      s.x1        = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'(int'(s.x0) + $urandom_range(0, 4));
      s.y1        = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'(int'(s.y0) + $urandom_range(0, 4));
      s.colour    = 12'($urandom);
      s.abort     = ($urandom_range(0, 24) == 0);
      apply(s);
    end
    repeat (3) apply(idle_s());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_fill_ctrl.md
VGA_FILL_CTRL -- requirements
Module: vga_fill_ctrl

Interface
REQ-001 The block SHALL have parameter DISPLAY_WIDTH, default 800, meaning visible pixels per line.
REQ-002 The block SHALL have parameter DISPLAY_HEIGHT, default 600, meaning visible lines.
REQ-003 The block SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  in  1  synchronous, active-low reset.
REQ-005 The block SHALL have port cpu_we  in  1  direct pixel-write strobe from the bus.
REQ-006 The block SHALL have port cpu_wdata  in  32  packed pixel {colour[31:20], y[19:10], x[9:0]}.
REQ-007 The block SHALL have port cmd_valid  in  1  rectangle-fill request.
REQ-008 The block SHALL have port cmd_ready  out  1  high when a fill command is accepted (state IDLE).
REQ-009 The block SHALL have ports cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  10 each  inclusive rectangle corners.
REQ-010 The block SHALL have port cmd_colour  in  12  fill colour.
REQ-011 The block SHALL have port abort  in  1  cancels the fill in progress.
REQ-012 The block SHALL have port busy  out  1  high while state is not IDLE.
REQ-013 The block SHALL have port done  out  1  one-cycle pulse when a fill completes normally.
REQ-014 The block SHALL have port vga_we  out  1  frame-buffer write strobe.
REQ-015 The block SHALL have port vga_wdata  out  32  packed pixel, same format as cpu_wdata.

Function
REQ-016 The block SHALL accept a command on a clock edge where cmd_valid and cmd_ready are both 1, and SHALL latch the corners and cmd_colour on that edge.
REQ-017 The FSM SHALL have states IDLE, FILL and DONE. IDLE goes to FILL on accept with a non-empty rectangle, and to DONE on accept with an empty one. FILL goes to DONE after the last pixel is issued, and to IDLE on abort. DONE goes to IDLE after exactly one cycle.
REQ-018 On accept, x1 SHALL be clamped to DISPLAY_WIDTH-1 and y1 to DISPLAY_HEIGHT-1.
REQ-019 The rectangle SHALL be empty if x0>x1, y0>y1, x0>=DISPLAY_WIDTH or y0>=DISPLAY_HEIGHT; an empty rectangle produces zero writes.
REQ-020 FILL SHALL issue pixels in raster order, x inner and y outer, starting at (x0,y0) and ending at (x1,y1), one pixel per unstalled cycle.
REQ-021 cpu_we SHALL have strict priority: in a cycle with cpu_we=1, the fill counters hold and cpu_wdata is forwarded.
REQ-022 vga_we and vga_wdata SHALL be registered outputs: a source selected in cycle N appears on the outputs in cycle N+1.
REQ-023 vga_wdata SHALL hold its last value while vga_we=0.
REQ-024 A fill of P pixels with S cpu_we stalls SHALL produce exactly P fill writes within P+S cycles after the accept edge.
REQ-025 Fill writes SHALL never be dropped or duplicated when interleaved with cpu_we.
REQ-026 done SHALL be asserted only in state DONE; abort SHALL NOT produce done.
REQ-027 abort SHALL be ignored outside FILL.
REQ-028 When abort and the last-pixel edge coincide, abort SHALL win: no done, but the last pixel is still written.
REQ-029 cmd_valid in any state other than IDLE SHALL be ignored without being latched.
REQ-030 The coordinate counters SHALL be 10 bits wide and SHALL never exceed the clamped corners.

Reset
REQ-031 When rst=0 at a clock edge, the FSM SHALL go to IDLE, and vga_we, busy and done SHALL be 0, vga_wdata 32'h0 and counters 0.
REQ-032 After reset, cmd_ready SHALL be 1.
REQ-033 A reset asserted mid-fill SHALL stop all writes from the next cycle, and SHALL NOT produce done.

Structure
REQ-034 The packed-pixel field positions (X_LSB=0, Y_LSB=10, C_LSB=20, widths 10/10/12) and the state encodings SHALL be defined in a shared package, vga_pkg.
REQ-035 A sub-module vga_raster_counter SHALL implement the x/y stepping, with inputs load, enable, x0, x1, y0, y1 and outputs x, y, last.

Verification
REQ-036 Reset then cmd (2,3)-(4,3), colour 12'hF0F: vga_we high for 3 cycles carrying 0xF0F00C02, 0xF0F00C03 and 0xF0F00C04, then done for one cycle.
REQ-037 cmd (0,0)-(1,1) with cpu_we=1, cpu_wdata=32'h00100005 on the second fill cycle: writes in order (0,0), the CPU pixel, (1,0), (0,1), (1,1); 5 writes total.
REQ-038 cmd (798,599)-(1023,1023): clamped to (798,599)-(799,599); exactly 2 writes.
REQ-039 cmd x0=5, x1=4: no vga_we, done pulses one cycle after accept, cmd_ready returns to 1.
REQ-040 cmd (0,0)-(799,599) with abort after 100 writes: no further writes, no done, busy=0 next cycle; rst=0 mid-fill likewise halts writes.
